// File: rtl/ctl_diag.sv
// ctl_diag: CTL board diagnostic-function sequencer.
// Synchronises EBUS_DS_STROBE and runs one WRITE/READ/CLEAR per accepted strobe.
module ctl_diag #(
    parameter int WIDTH = 36,
    parameter int NREG  = 8,
    parameter int SYNC  = 2
) (
    input  logic                  eboxClk,
    input  logic                  CROBAR,
    input  logic                  EBUS_DS_STROBE,
    input  logic [0:6]            EBUS_DS,
    input  logic [WIDTH-1:0]      EBUS_DATA,
    output logic [WIDTH-1:0]      CTL_EBUS,
    output logic                  CTL_EBUS_EN,
    output logic [NREG*WIDTH-1:0] CTL_DIAG_REGS,
    output logic                  CTL_DIAG_ACK,
    output logic                  CTL_DIAG_BUSY,
    output logic                  CTL_DIAG_ERR
);

    if (NREG < 1 || NREG > 32) begin : g_bad_nreg
        $error("ctl_diag: NREG must be 1..32");
    end
    if (SYNC < 2) begin : g_bad_sync
        $error("ctl_diag: SYNC must be at least 2");
    end

    localparam logic [5:0] NREG_W = 6'(NREG);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD,
        WAIT_LOW
    } state_t;

    typedef enum logic [1:0] {
        OP_WR,
        OP_RD,
        OP_CLR,
        OP_ILL
    } op_t;

    state_t           state_q;
    state_t           state_d;
    op_t              op;
    logic [SYNC-1:0]  sync_q;
    logic             prev_q;
    logic             synced;
    logic             rise;
    logic             cap;
    logic             exec;
    logic [6:0]       ds_reg;
    logic [WIDTH-1:0] data_reg;
    logic [4:0]       n;
    logic             in_range;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] ebus_q;
    logic             en_q;
    logic             ack_q;
    logic             err_q;

    // Chain and history reset high so a strobe held through reset is not a rise
    always_ff @(posedge eboxClk or posedge CROBAR) begin
        if (CROBAR) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], EBUS_DS_STROBE};
            prev_q <= sync_q[SYNC-1];
        end
    end

    assign synced = sync_q[SYNC-1];
    assign rise   = synced & ~prev_q;
    assign n      = ds_reg[4:0];
    assign in_range = ({1'b0, n} < NREG_W);

    always_comb begin
        op = OP_ILL;
        unique case (1'b1)
            (ds_reg[6:5] == 2'b00): op = in_range ? OP_WR : OP_ILL;
            (ds_reg[6:5] == 2'b01): op = in_range ? OP_RD : OP_ILL;
            (ds_reg == 7'h7F):      op = OP_CLR;
            default:                op = OP_ILL;
        endcase
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NREG; i++) begin
            if (n == 5'(i)) rd_data = regs_q[i];
        end
    end

    always_ff @(posedge eboxClk or posedge CROBAR) begin
        if (CROBAR) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        exec    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = EXEC;
                    cap     = 1'b1;
                end
            end
            EXEC: begin
                exec    = 1'b1;
                state_d = (op == OP_RD) ? HOLD : WAIT_LOW;
            end
            HOLD, WAIT_LOW: begin
                if (!synced) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge eboxClk or posedge CROBAR) begin
        if (CROBAR) begin
            ds_reg   <= '0;
            data_reg <= '0;
            ebus_q   <= '0;
            en_q     <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            ack_q <= exec;
            if (cap) begin
                ds_reg   <= EBUS_DS;
                data_reg <= EBUS_DATA;
            end
            if (exec) begin
                unique case (op)
                    OP_WR: begin
                        for (int i = 0; i < NREG; i++) begin
                            if (n == 5'(i)) regs_q[i] <= data_reg;
                        end
                    end
                    OP_RD: begin
                        ebus_q <= rd_data;
                        en_q   <= 1'b1;
                    end
                    OP_CLR: begin
                        for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
                        err_q <= 1'b0;
                    end
                    default: err_q <= 1'b1;
                endcase
            end
            // Readback value stays frozen until the strobe is seen low
            if (state_q == HOLD && !synced) begin
                ebus_q <= '0;
                en_q   <= 1'b0;
            end
        end
    end

    always_comb begin
        CTL_DIAG_REGS = '0;
        for (int i = 0; i < NREG; i++) begin
            CTL_DIAG_REGS[i*WIDTH +: WIDTH] = regs_q[i];
        end
    end

    assign CTL_EBUS      = ebus_q;
    assign CTL_EBUS_EN   = en_q;
    assign CTL_DIAG_ACK  = ack_q;
    assign CTL_DIAG_BUSY = (state_q != IDLE);
    assign CTL_DIAG_ERR  = err_q;

endmodule
